// File: rtl/bsg_manycore_cache_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bsg_manycore_cache_arbiter_pkg
//
// Shared declarations for the manycore cache arbiter.
//   lock_state_e : state of the per-requester burst lock.
// The arbiter itself is width-parameterized only; this package carries the
// lock FSM encoding so the arbiter and its checker agree on it.
// ---------------------------------------------------------------------------
package bsg_manycore_cache_arbiter_pkg;

   typedef enum logic [0:0] {
      LOCK_UNLOCKED = 1'b0,
      LOCK_LOCKED   = 1'b1
   } lock_state_e;

endpackage

// File: rtl/bsg_manycore_cache_arbiter_chk.sv
// ---------------------------------------------------------------------------
// bsg_manycore_cache_arbiter_chk
//
// Simulation-only property checker for the arbiter's internal indices and
// one-hot routing outputs. No logic is driven from here.
//   clk_i, reset_i      : arbiter clock / synchronous reset
//   grant_id_i          : current grant index
//   rr_ptr_i, lock_id_i : round-robin pointer and lock owner
//   tl_id_i, tv_id_i    : owners of the tag-lookup / tag-verify stages
//   req_v_o_i           : routed response valids
//   req_v_we_o_i        : routed tl->tv advance strobes
// ---------------------------------------------------------------------------
module bsg_manycore_cache_arbiter_chk #(
   parameter int num_req_p     = 2,
   parameter int lg_num_req_lp = 1
) (
   input logic                     clk_i,
   input logic                     reset_i,
   input logic [lg_num_req_lp-1:0] grant_id_i,
   input logic [lg_num_req_lp-1:0] rr_ptr_i,
   input logic [lg_num_req_lp-1:0] lock_id_i,
   input logic [lg_num_req_lp-1:0] tl_id_i,
   input logic [lg_num_req_lp-1:0] tv_id_i,
   input logic [num_req_p-1:0]     req_v_o_i,
   input logic [num_req_p-1:0]     req_v_we_o_i
);

   a_grant_range : assert property (@(posedge clk_i) disable iff (reset_i)
      int'(grant_id_i) < num_req_p);
   a_ptr_range   : assert property (@(posedge clk_i) disable iff (reset_i)
      int'(rr_ptr_i) < num_req_p);
   a_lock_range  : assert property (@(posedge clk_i) disable iff (reset_i)
      int'(lock_id_i) < num_req_p);
   a_tl_range    : assert property (@(posedge clk_i) disable iff (reset_i)
      int'(tl_id_i) < num_req_p);
   a_tv_range    : assert property (@(posedge clk_i) disable iff (reset_i)
      int'(tv_id_i) < num_req_p);
   a_v_onehot    : assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(req_v_o_i));
   a_we_onehot   : assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(req_v_we_o_i));

endmodule

// File: rtl/bsg_manycore_cache_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bsg_manycore_cache_arbiter_rr
//
// Purely combinational round-robin grant with a force override.
//   v_i        : per-requester valid
//   ptr_i      : index where the round-robin search starts
//   force_v_i  : when set, the grant is pinned to force_id_i
//   force_id_i : pinned grant index (the lock owner)
//   grant_v_o  : valid of the granted requester
//   grant_id_o : granted index (meaningful only while grant_v_o = 1)
// ---------------------------------------------------------------------------
module bsg_manycore_cache_arbiter_rr #(
   parameter int num_req_p     = 2,
   parameter int lg_num_req_lp = 1
) (
   input  logic [num_req_p-1:0]     v_i,
   input  logic [lg_num_req_lp-1:0] ptr_i,
   input  logic                     force_v_i,
   input  logic [lg_num_req_lp-1:0] force_id_i,
   output logic                     grant_v_o,
   output logic [lg_num_req_lp-1:0] grant_id_o
);

   logic                     rr_v;
   logic [lg_num_req_lp-1:0] rr_id;
   logic [lg_num_req_lp-1:0] cand;

   // (base + off) mod num_req_p, with base < num_req_p and off < num_req_p
   function automatic logic [lg_num_req_lp-1:0] wrap_add(
      input logic [lg_num_req_lp-1:0] base,
      input int                       off
   );
      int sum;
      sum = int'(base) + off;
      return lg_num_req_lp'((sum >= num_req_p) ? (sum - num_req_p) : sum);
   endfunction

   // Rotating priority search: walking offsets from high to low lets the
   // smallest offset from ptr_i win, which is the first valid at/after ptr_i.
   always_comb begin
      rr_v  = 1'b0;
      rr_id = ptr_i;
      cand  = '0;
      for (int i = num_req_p - 1; i >= 0; i--) begin
         cand  = wrap_add(ptr_i, i);
         rr_v  = rr_v | v_i[cand];
         rr_id = v_i[cand] ? cand : rr_id;
      end
   end

   // The lock pins the grant even when the owner is momentarily not valid.
   assign grant_v_o  = force_v_i ? v_i[force_id_i] : rr_v;
   assign grant_id_o = force_v_i ? force_id_i      : rr_id;

endmodule

// File: rtl/bsg_manycore_cache_arbiter.sv
// ---------------------------------------------------------------------------
// bsg_manycore_cache_arbiter
//
// Lets num_req_p link-to-cache adapters share one bsg_cache. Packets are
// arbitrated round-robin; a requester may hold the grant across a burst by
// raising req_lock_i. The owner of the packet in the cache's tag-lookup (tl)
// and tag-verify (tv) stages is tracked so that v_we and responses return to
// the requester that issued them. All request/response paths are
// combinational.
//
// Ports
//   clk_i, reset_i     : clock, synchronous active-high reset
//   req_cache_pkt_i    : per-requester packet
//   req_v_i            : per-requester packet valid
//   req_lock_i         : keep the grant after this packet is accepted
//   req_yumi_o         : packet accepted (one-hot)
//   req_data_o         : response data, broadcast
//   req_v_o            : response valid (one-hot, to tv owner)
//   req_yumi_i         : requester consumes its response
//   req_v_we_o         : tl->tv advance strobe (one-hot, to tl owner)
//   cache_pkt_o, v_o   : muxed packet and valid to the cache
//   yumi_i             : cache accepts the packet
//   data_i, v_i        : cache response data / valid
//   yumi_o             : response consumed
//   v_we_i             : cache tl->tv advance
// ---------------------------------------------------------------------------
module bsg_manycore_cache_arbiter
   import bsg_manycore_cache_arbiter_pkg::*;
#(
   parameter int num_req_p         = 2,
   parameter int cache_pkt_width_p = 32,
   parameter int data_width_p      = 32
) (
   input  logic                                        clk_i,
   input  logic                                        reset_i,

   input  logic [num_req_p-1:0][cache_pkt_width_p-1:0] req_cache_pkt_i,
   input  logic [num_req_p-1:0]                        req_v_i,
   input  logic [num_req_p-1:0]                        req_lock_i,
   output logic [num_req_p-1:0]                        req_yumi_o,

   output logic [data_width_p-1:0]                     req_data_o,
   output logic [num_req_p-1:0]                        req_v_o,
   input  logic [num_req_p-1:0]                        req_yumi_i,
   output logic [num_req_p-1:0]                        req_v_we_o,

   output logic [cache_pkt_width_p-1:0]                cache_pkt_o,
   output logic                                        v_o,
   input  logic                                        yumi_i,

   input  logic [data_width_p-1:0]                     data_i,
   input  logic                                        v_i,
   output logic                                        yumi_o,
   input  logic                                        v_we_i
);

   localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   lock_state_e              state_q,   state_d;
   logic [lg_num_req_lp-1:0] rr_ptr_q,  rr_ptr_d;
   logic [lg_num_req_lp-1:0] lock_id_q, lock_id_d;
   logic [lg_num_req_lp-1:0] tl_id_q,   tl_id_d;
   logic [lg_num_req_lp-1:0] tv_id_q,   tv_id_d;

   logic                     grant_v;
   logic [lg_num_req_lp-1:0] grant_id;

   // index + 1 mod num_req_p
   function automatic logic [lg_num_req_lp-1:0] next_idx(
      input logic [lg_num_req_lp-1:0] idx
   );
      return (idx == lg_num_req_lp'(num_req_p - 1)) ? '0 : (idx + 1'b1);
   endfunction

   bsg_manycore_cache_arbiter_rr #(
      .num_req_p     (num_req_p),
      .lg_num_req_lp (lg_num_req_lp)
   ) rr (
      .v_i        (req_v_i),
      .ptr_i      (rr_ptr_q),
      .force_v_i  (state_q == LOCK_LOCKED),
      .force_id_i (lock_id_q),
      .grant_v_o  (grant_v),
      .grant_id_o (grant_id)
   );

   assign v_o         = grant_v;
   assign cache_pkt_o = req_cache_pkt_i[grant_id];
   assign req_data_o  = data_i;
   assign yumi_o      = req_yumi_i[tv_id_q];

   // Steer accept, advance and response strobes to their single owner.
   always_comb begin
      req_yumi_o           = '0;
      req_v_we_o           = '0;
      req_v_o              = '0;
      req_yumi_o[grant_id] = yumi_i;
      req_v_we_o[tl_id_q]  = v_we_i;
      req_v_o[tv_id_q]     = v_i;
   end

   // Lock FSM and round-robin pointer next state. The pointer only moves on
   // an unlocked, non-locking accept or on lock release, so a burst does not
   // perturb the fairness order.
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         LOCK_UNLOCKED: begin
            if (yumi_i) begin
               if (req_lock_i[grant_id]) begin
                  state_d   = LOCK_LOCKED;
                  lock_id_d = grant_id;
               end else begin
                  rr_ptr_d  = next_idx(grant_id);
               end
            end else begin
               state_d = LOCK_UNLOCKED;
            end
         end
         LOCK_LOCKED: begin
            if (yumi_i && !req_lock_i[lock_id_q]) begin
               state_d  = LOCK_UNLOCKED;
               rr_ptr_d = next_idx(lock_id_q);
            end else begin
               state_d  = LOCK_LOCKED;
            end
         end
         default: begin
            state_d = LOCK_UNLOCKED;
         end
      endcase
   end

   // Stage ownership: tv inherits the pre-edge tl owner even when a new
   // packet enters tl in the same cycle.
   always_comb begin
      tl_id_d = yumi_i ? grant_id : tl_id_q;
      tv_id_d = v_we_i ? tl_id_q  : tv_id_q;
   end

   // State registers; reset drops any lock and in-flight ownership.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= LOCK_UNLOCKED;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
         tl_id_q   <= '0;
         tv_id_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_id_q <= lock_id_d;
         tl_id_q   <= tl_id_d;
         tv_id_q   <= tv_id_d;
      end
   end

   bsg_manycore_cache_arbiter_chk #(
      .num_req_p     (num_req_p),
      .lg_num_req_lp (lg_num_req_lp)
   ) chk (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .grant_id_i   (grant_id),
      .rr_ptr_i     (rr_ptr_q),
      .lock_id_i    (lock_id_q),
      .tl_id_i      (tl_id_q),
      .tv_id_i      (tv_id_q),
      .req_v_o_i    (req_v_o),
      .req_v_we_o_i (req_v_we_o)
   );

endmodule

// File: tb/tb_bsg_manycore_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_cache_arbiter
//
// Directed scenarios for grant order, locking, reset and routing, followed
// by randomized traffic against a behavioural arbiter/cache model.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_cache_arbiter;

   localparam int N  = 4;
   localparam int PW = 16;
   localparam int DW = 16;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic [N-1:0][PW-1:0]  req_cache_pkt_i;
   logic [N-1:0]          req_v_i;
   logic [N-1:0]          req_lock_i;
   logic [N-1:0]          req_yumi_o;
   logic [DW-1:0]         req_data_o;
   logic [N-1:0]          req_v_o;
   logic [N-1:0]          req_yumi_i;
   logic [N-1:0]          req_v_we_o;
   logic [PW-1:0]         cache_pkt_o;
   logic                  v_o;
   logic                  yumi_i;
   logic [DW-1:0]         data_i;
   logic                  v_i;
   logic                  yumi_o;
   logic                  v_we_i;

   always #5 clk_i = ~clk_i;

   bsg_manycore_cache_arbiter #(
      .num_req_p         (N),
      .cache_pkt_width_p (PW),
      .data_width_p      (DW)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .req_cache_pkt_i (req_cache_pkt_i),
      .req_v_i         (req_v_i),
      .req_lock_i      (req_lock_i),
      .req_yumi_o      (req_yumi_o),
      .req_data_o      (req_data_o),
      .req_v_o         (req_v_o),
      .req_yumi_i      (req_yumi_i),
      .req_v_we_o      (req_v_we_o),
      .cache_pkt_o     (cache_pkt_o),
      .v_o             (v_o),
      .yumi_i          (yumi_i),
      .data_i          (data_i),
      .v_i             (v_i),
      .yumi_o          (yumi_o),
      .v_we_i          (v_we_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] dpkt(input int r);
      return 16'hA000 | 16'(r);
   endfunction

   function automatic logic [N-1:0] oh(input int r);
      return 4'b0001 << r;
   endfunction

   task automatic zero_inputs();
      for (int r = 0; r < N; r++) req_cache_pkt_i[r] = dpkt(r);
      req_v_i    = '0;
      req_lock_i = '0;
      req_yumi_i = '0;
      yumi_i     = 1'b0;
      data_i     = '0;
      v_i        = 1'b0;
      v_we_i     = 1'b0;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      zero_inputs();
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   // ---------------- behavioural model state for random traffic ----------
   logic [PW-1:0] pend_pkt [N];
   bit            pend_v   [N];
   bit            pend_lock[N];
   int            burst_left[N];
   logic [13:0]   seq      [N];
   int            m_owner;       // -1 when no requester holds the lock
   int            m_ptr;
   bit            tl_v, tv_v;
   logic [PW-1:0] tl_pkt, tv_pkt;
   logic [PW-1:0] iss_q[$];
   int            issue_cnt, resp_cnt;

   task automatic model_clear();
      for (int r = 0; r < N; r++) begin
         pend_v[r] = 1'b0; pend_lock[r] = 1'b0; burst_left[r] = 0; seq[r] = 14'd0;
         pend_pkt[r] = '0;
      end
      m_owner = -1; m_ptr = 0;
      tl_v = 1'b0; tv_v = 1'b0; tl_pkt = '0; tv_pkt = '0;
      iss_q.delete();
      issue_cnt = 0; resp_cnt = 0;
   endtask

   task automatic rand_cycle(input bit gen_on);
      int            g;
      int            tvid;
      logic [PW-1:0] front;
      for (int r = 0; r < N; r++) begin
         if (!pend_v[r] && (gen_on || burst_left[r] > 0) && $urandom_range(0, 99) < 45) begin
            pend_v[r]   = 1'b1;
            pend_pkt[r] = {2'(r), seq[r]};
            seq[r]      = seq[r] + 14'd1;
            if (burst_left[r] == 0)
               burst_left[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
            pend_lock[r] = (burst_left[r] > 1);
         end
         req_v_i[r]         = pend_v[r];
         req_cache_pkt_i[r] = pend_v[r] ? pend_pkt[r] : 16'($urandom);
         req_lock_i[r]      = pend_v[r] ? pend_lock[r] : 1'($urandom);
         req_yumi_i[r]      = ($urandom_range(0, 99) < 60);
      end
      v_i    = tv_v;
      data_i = tv_v ? tv_pkt : 16'($urandom);
      v_we_i = tl_v && !tv_v && ($urandom_range(0, 3) != 0);

      // Expected grant: lock owner if any, else first pending at/after pointer.
      g = -1;
      if (m_owner >= 0) begin
         if (pend_v[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && pend_v[idx]) g = idx;
         end
      end
      yumi_i = (g >= 0) && (!tl_v || v_we_i) && ($urandom_range(0, 99) < 70);
      #1;

      chk("v_o", 32'(v_o), (g >= 0) ? 32'd1 : 32'd0);
      if (g >= 0) chk("cache_pkt_o", 32'(cache_pkt_o), 32'(pend_pkt[g]));
      chk("req_yumi_o", 32'(req_yumi_o), (yumi_i && g >= 0) ? 32'(oh(g)) : 32'd0);
      chk("req_v_we_o", 32'(req_v_we_o), v_we_i ? 32'(oh(int'(tl_pkt[15:14]))) : 32'd0);
      chk("req_v_o", 32'(req_v_o), v_i ? 32'(oh(int'(tv_pkt[15:14]))) : 32'd0);
      if (tv_v) begin
         tvid = int'(tv_pkt[15:14]);
         chk("yumi_o", 32'(yumi_o), 32'(req_yumi_i[tvid]));
         chk("req_data_o", 32'(req_data_o), 32'(tv_pkt));
      end
      // Requester view: whatever a requester consumes must be the oldest
      // outstanding packet, and it must be that requester's own packet.
      for (int r = 0; r < N; r++) begin
         if (req_v_o[r] && req_yumi_i[r]) begin
            resp_cnt++;
            if (iss_q.size() == 0) begin
               chk("resp_extra", 32'(iss_q.size()), 32'd1);
            end else begin
               front = iss_q.pop_front();
               chk("resp_data", 32'(req_data_o), 32'(front));
               chk("resp_dest", 32'(r), 32'(front[15:14]));
            end
         end
      end

      @(posedge clk_i);
      if (v_i && yumi_o) tv_v = 1'b0;
      if (v_we_i) begin
         tv_v = 1'b1; tv_pkt = tl_pkt; tl_v = 1'b0;
      end
      if (yumi_i) begin
         tl_v = 1'b1; tl_pkt = pend_pkt[g];
         iss_q.push_back(pend_pkt[g]);
         issue_cnt++;
         pend_v[g] = 1'b0;
         burst_left[g]--;
         if (m_owner >= 0) begin
            if (!pend_lock[g]) begin m_owner = -1; m_ptr = (g + 1) % N; end
         end else if (pend_lock[g]) begin
            m_owner = g;
         end else begin
            m_ptr = (g + 1) % N;
         end
      end
      @(negedge clk_i);
   endtask

   // Lock scenario table: req_v, lock on req 2, yumi, expected v_o, expected grant
   logic [3:0] lk_rv [7] = '{4'b1101, 4'b1001, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
   bit         lk_lk [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   bit         lk_yu [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   bit         lk_ev [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   int         lk_eg [7] = '{2, 2, 2, 2, 2, 3, 0};

   initial begin
      bit done;
      zero_inputs();
      reset_i = 1'b1;
      do_reset();

      // Reset state: nothing valid, nothing routed.
      #1;
      chk("rst_v_o", 32'(v_o), 32'd0);
      chk("rst_req_yumi_o", 32'(req_yumi_o), 32'd0);
      chk("rst_req_v_o", 32'(req_v_o), 32'd0);
      chk("rst_req_v_we_o", 32'(req_v_we_o), 32'd0);
      chk("rst_yumi_o", 32'(yumi_o), 32'd0);
      @(negedge clk_i);

      // Two requesters always valid, no lock: grants alternate 0,1,0,1.
      for (int k = 0; k < 4; k++) begin
         req_v_i = 4'b0011; yumi_i = 1'b1;
         #1;
         chk("rr_alt_pkt", 32'(cache_pkt_o), 32'(dpkt(k % 2)));
         chk("rr_alt_yumi", 32'(req_yumi_o), 32'(oh(k % 2)));
         @(negedge clk_i);
      end

      // Burst lock on requester 2 (pointer now at 2), then 3, then 0.
      for (int k = 0; k < 7; k++) begin
         req_v_i = lk_rv[k]; req_lock_i = lk_lk[k] ? 4'b0100 : 4'b0000; yumi_i = lk_yu[k];
         #1;
         chk("lock_v_o", 32'(v_o), 32'(lk_ev[k]));
         if (lk_ev[k]) chk("lock_grant", 32'(cache_pkt_o), 32'(dpkt(lk_eg[k])));
         @(negedge clk_i);
      end

      // Reset while locked on requester 3 (pointer is at 1).
      req_v_i = 4'b1000; req_lock_i = 4'b1000; yumi_i = 1'b1;
      #1;
      chk("lk3_grant", 32'(cache_pkt_o), 32'(dpkt(3)));
      @(negedge clk_i);
      req_v_i = 4'b1011; yumi_i = 1'b0;
      #1;
      chk("lk3_hold", 32'(cache_pkt_o), 32'(dpkt(3)));
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0; v_we_i = 1'b1; v_i = 1'b1;
      #1;
      chk("rstlk_grant", 32'(cache_pkt_o), 32'(dpkt(0)));
      chk("rstlk_v_o", 32'(v_o), 32'd1);
      chk("rstlk_we", 32'(req_v_we_o), 32'(4'b0001));
      chk("rstlk_rv", 32'(req_v_o), 32'(4'b0001));
      @(negedge clk_i);
      zero_inputs();
      @(negedge clk_i);

      // yumi and v_we in the same cycle: req 1 then req 0 back to back.
      req_v_i = 4'b0010; yumi_i = 1'b1;
      #1;
      chk("bb_yumi1", 32'(req_yumi_o), 32'(4'b0010));
      @(negedge clk_i);
      req_v_i = 4'b0001; yumi_i = 1'b1; v_we_i = 1'b1;
      #1;
      chk("bb_yumi0", 32'(req_yumi_o), 32'(4'b0001));
      chk("bb_we_old", 32'(req_v_we_o), 32'(4'b0010));
      @(negedge clk_i);
      // Response backpressure from the tv owner (req 1) for three cycles.
      req_v_i = '0; yumi_i = 1'b0; v_we_i = 1'b0; v_i = 1'b1; data_i = 16'h5A5A;
      req_yumi_i = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_yumi_o", 32'(yumi_o), 32'd0);
         chk("bp_req_v_o", 32'(req_v_o), 32'(4'b0010));
         chk("bp_data", 32'(req_data_o), 32'h5A5A);
         @(negedge clk_i);
      end
      req_yumi_i = 4'b0010; v_we_i = 1'b1;
      #1;
      chk("bp_release", 32'(yumi_o), 32'd1);
      chk("bb_we_new", 32'(req_v_we_o), 32'(4'b0001));
      chk("bb_rv", 32'(req_v_o), 32'(4'b0010));
      @(negedge clk_i);

      // Randomized traffic against the behavioural model.
      do_reset();
      model_clear();
      for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         rand_cycle(1'b0);
         done = !tl_v && !tv_v;
         for (int r = 0; r < N; r++) if (pend_v[r] || burst_left[r] > 0) done = 1'b0;
      end
      chk("drain_done", 32'(done), 32'd1);
      chk("drain_left", 32'(iss_q.size()), 32'd0);
      chk("resp_total", 32'(resp_cnt), 32'(issue_cnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_cache_arbiter.md
# bsg_manycore_cache_arbiter

Lets N manycore link-to-cache adapters share one `bsg_cache` instance.
- Arbitrates cache packets round-robin, with an optional per-requester lock for multi-packet bursts such as icache block fetches.
- Tracks which requester owns each packet in the cache's tag-lookup (tl) and tag-verify (tv) stages.
- Routes the cache's `v_we` strobe and its response data back to the owning requester.
- Sits between the adapters' cache-side ports and a single `bsg_cache`.

## Interface
Parameters:
- `num_req_p`, none (`BSG_INV_PARAM`): number of requesters, ≥2.
- `cache_pkt_width_p`, none: width of the `bsg_cache` packet.
- `data_width_p`, none: width of cache response data.
- `lg_num_req_lp`, localparam: `BSG_SAFE_CLOG2(num_req_p)`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous active-high reset.
- `req_cache_pkt_i`  in  num_req_p×cache_pkt_width_p  per-requester packet.
- `req_v_i`  in  num_req_p  per-requester packet valid.
- `req_lock_i`  in  num_req_p  keep the grant after this packet is accepted.
- `req_yumi_o`  out  num_req_p  packet accepted by the cache.
- `req_data_o`  out  data_width_p  response data, broadcast to all requesters.
- `req_v_o`  out  num_req_p  response valid, one-hot.
- `req_yumi_i`  in  num_req_p  requester consumes the response.
- `req_v_we_o`  out  num_req_p  tl→tv advance strobe, one-hot.
- `cache_pkt_o`  out  cache_pkt_width_p  muxed packet to the cache.
- `v_o`  out  1  packet valid to the cache.
- `yumi_i`  in  1  cache accepts the packet.
- `data_i`  in  data_width_p  cache response data.
- `v_i`  in  1  cache response valid.
- `yumi_o`  out  1  response consumed.
- `v_we_i`  in  1  cache tl→tv advance.

## Operation
- Grant selection:
  - Round-robin over `req_v_i`. Search starts at `rr_ptr_r` and picks the first valid index at or above it, with wrap-around.
  - When `lock_v_r`=1, the grant is forced to `lock_id_r` regardless of other valids.
- Request side:
  - `v_o` = valid of the granted requester; in locked mode that is `req_v_i[lock_id_r]`.
  - `cache_pkt_o` = granted requester's packet.
  - `req_yumi_o[g]` = `yumi_i`; all other bits 0.
- Round-robin pointer: on `yumi_i` with no lock active or taken, `rr_ptr_r` ← (g+1) mod `num_req_p`. While locked, the pointer holds.
- Lock FSM, two states:
  - UNLOCKED → LOCKED on `yumi_i & req_lock_i[g]`. Sets `lock_id_r`=g.
  - LOCKED → UNLOCKED on `yumi_i & ~req_lock_i[lock_id_r]`. On release, `rr_ptr_r` ← `lock_id_r`+1 mod N.
  - Lock is sampled only at accept. A requester dropping `req_v_i` while locked does not release the lock.
- Ownership tracking:
  - `tl_id_r` ← g on `yumi_i`.
  - `tv_id_r` ← `tl_id_r` on `v_we_i`.
  - If both occur in the same cycle, `tv_id_r` takes the old `tl_id_r`.
- Routing:
  - `req_v_we_o[tl_id_r]` = `v_we_i`.
  - `req_v_o[tv_id_r]` = `v_i`.
  - `yumi_o` = `req_yumi_i[tv_id_r]`.
  - `req_data_o` = `data_i`.
  - All non-owner bits are 0.
- Index values ≥ `num_req_p` are unreachable; assert in simulation.

## Timing
- Zero-latency combinational paths:
  - request: `req_v_i` → `v_o`;
  - accept: `yumi_i` → `req_yumi_o`;
  - response: `v_i` → `req_v_o` and `req_yumi_i` → `yumi_o`.
- No added pipeline stage on either path.
- Reset values:
  - state UNLOCKED; `rr_ptr_r`, `lock_id_r`, `tl_id_r`, `tv_id_r` = 0.
  - All outputs follow combinationally from these. With no inputs, every valid/yumi/v_we output is 0.
- Reset asserted mid-burst clears the lock immediately. Any in-flight tracking is discarded, and the cache must be reset together with this block.
- `v_o` never depends on `yumi_i`. Valid/yumi rule: a requester must not drop `req_v_i` without `req_yumi_o`, except during reset.
- The cache holds at most one packet in tl and one in tv. The two id registers are therefore sufficient, and no FIFO is needed.

## Structure
- No new package types. The block is width-parameterized only.
- One sub-module: `bsg_arb_round_robin` (existing) or an equivalent local rotate/priority-encode function producing one-hot grant plus index, with the lock forcing its input.
- The lock FSM and the id registers live in this module.

## Test plan
- N=2, both valid every cycle, no lock → grants alternate 0,1,0,1; `rr_ptr_r` toggles on each `yumi_i`.
- N=4, req 2 asserts `req_lock_i` for 4 packets (icache fetch), req 0 and req 3 are valid throughout → 4 consecutive grants to 2. Then grant goes to 3, then 0.
- `yumi_i` and `v_we_i` in the same cycle (req 1 then req 0 back-to-back) → next `v_i` raises `req_v_o`=2'b10, next `req_v_we_o`=2'b01.
- Response backpressure: `v_i`=1 with `req_yumi_i[tv]`=0 for 3 cycles → `yumi_o`=0 throughout. `tv_id_r` is stable; it advances only on `v_we_i`.
- Reset asserted while LOCKED on req 3 → next cycle UNLOCKED, grant to the lowest valid index ≥0, all id registers 0.
- Randomized valid/lock/backpressure with a `bsg_cache` model → every response reaches its issuing requester in order. No response is duplicated or lost.
